// File: rtl/frame_rr_arbiter.sv
// frame_rr_arbiter: frame-granular round-robin arbiter feeding the engine input FIFO.
// One source owns the FIFO from its first beat to slv_last (or the MAXBEATS limit),
// then every source is held off until the engine reports proc_cmplt.
module frame_rr_arbiter #(
  parameter int DW       = 32,
  parameter int NSLV     = 2,
  parameter int MAXBEATS = 4096,
  localparam int SW      = $clog2(NSLV),
  localparam int CW      = $clog2(MAXBEATS) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2*NSLV-1:0]    slv_mode,
  input  logic [NSLV-1:0]      slv_req,
  input  logic [NSLV-1:0]      slv_valid,
  input  logic [DW*NSLV-1:0]   slv_data,
  input  logic [NSLV-1:0]      slv_last,
  output logic [NSLV-1:0]      slv_ready,
  input  logic                 fifo_full,
  output logic                 fifo_wr,
  output logic [DW-1:0]        fifo_wdata,
  output logic [1:0]           mode_out,
  output logic [SW-1:0]        src_id,
  input  logic                 proc_cmplt,
  output logic                 busy,
  output logic                 ovf_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_XFER,
    S_WAIT
  } state_t;

  state_t          r_state;
  logic [SW-1:0]   r_rr_ptr;
  logic [SW-1:0]   r_src_id;
  logic [1:0]      r_mode;
  logic [CW-1:0]   r_beat_cnt;
  logic            r_fifo_wr;
  logic [DW-1:0]   r_wdata;
  logic            r_ovf;

  logic [NSLV-1:0] w_elig;
  logic [SW-1:0]   w_cand;
  logic            w_found;
  logic [SW-1:0]   w_pick;
  logic [1:0]      w_pick_mode;
  logic            w_sel_valid;
  logic            w_sel_last;
  logic [DW-1:0]   w_sel_data;
  logic            w_ready_bit;
  logic            w_xfer;
  logic            w_cnt_max;

  // A source competes only when it requests and is not in the inactive mode
  always_comb begin
    w_elig = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      w_elig[i] = slv_req[i] & (slv_mode[2*i +: 2] != 2'b00);
    end
  end

  // Round-robin search: first eligible index at or after rr_ptr, wrapping
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int unsigned k = 0; k < NSLV; k++) begin
      w_cand = SW'((32'(r_rr_ptr) + k) % NSLV);
      if (!w_found && w_elig[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  // Mode of the candidate and beat signals of the currently granted source
  always_comb begin
    w_pick_mode = '0;
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (SW'(i) == w_pick) begin
        w_pick_mode = slv_mode[2*i +: 2];
      end
      if (SW'(i) == r_src_id) begin
        w_sel_valid = slv_valid[i];
        w_sel_last  = slv_last[i];
        w_sel_data  = slv_data[i*DW +: DW];
      end
    end
  end

  // Ready follows fifo_full combinationally so a full FIFO stalls in the same cycle
  always_comb begin
    slv_ready = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      slv_ready[i] = w_ready_bit & (SW'(i) == r_src_id);
    end
  end

  assign w_ready_bit = (r_state == S_XFER) & ~fifo_full;
  assign w_xfer      = w_ready_bit & w_sel_valid;
  assign w_cnt_max   = (r_beat_cnt == CW'(MAXBEATS - 1));

  // Arbitration FSM with registered FIFO write path and overflow pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_src_id   <= '0;
      r_mode     <= '0;
      r_beat_cnt <= '0;
      r_fifo_wr  <= 1'b0;
      r_wdata    <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_fifo_wr <= w_xfer;
      r_ovf     <= 1'b0;
      if (w_xfer) begin
        r_wdata <= w_sel_data;
      end
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_src_id <= w_pick;
            r_mode   <= w_pick_mode;
            r_state  <= S_GRANT;
          end
        end
        S_GRANT: begin
          r_beat_cnt <= '0;
          r_state    <= S_XFER;
        end
        S_XFER: begin
          if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            if (w_sel_last) begin
              r_state <= S_WAIT;
            end else if (w_cnt_max) begin
              r_ovf   <= 1'b1;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (proc_cmplt) begin
            r_rr_ptr <= (r_src_id == SW'(NSLV - 1)) ? '0 : r_src_id + 1'b1;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign fifo_wr    = r_fifo_wr;
  assign fifo_wdata = r_wdata;
  assign mode_out   = r_mode;
  assign src_id     = r_src_id;
  assign ovf_err    = r_ovf;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_frame_rr_arbiter.sv
// Scoreboard bench for frame_rr_arbiter (NSLV=2, DW=32, MAXBEATS=8).
module tb_frame_rr_arbiter;
  localparam int DW   = 32;
  localparam int NSLV = 2;
  localparam int MAXB = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [2*NSLV-1:0] slv_mode;
  logic [NSLV-1:0]   slv_req;
  logic [NSLV-1:0]   slv_valid;
  logic [DW*NSLV-1:0] slv_data;
  logic [NSLV-1:0]   slv_last;
  logic [NSLV-1:0]   slv_ready;
  logic              fifo_full;
  logic              fifo_wr;
  logic [DW-1:0]     fifo_wdata;
  logic [1:0]        mode_out;
  logic [0:0]        src_id;
  logic              proc_cmplt;
  logic              busy;
  logic              ovf_err;

  frame_rr_arbiter #(.DW(DW), .NSLV(NSLV), .MAXBEATS(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .slv_mode(slv_mode), .slv_req(slv_req),
    .slv_valid(slv_valid), .slv_data(slv_data), .slv_last(slv_last),
    .slv_ready(slv_ready), .fifo_full(fifo_full), .fifo_wr(fifo_wr),
    .fifo_wdata(fifo_wdata), .mode_out(mode_out), .src_id(src_id),
    .proc_cmplt(proc_cmplt), .busy(busy), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        ovf;
    int          cyc;
  } exp_t;

  typedef struct {
    int          src;
    logic [1:0]  mode;
  } gnt_t;

  exp_t exp_q[$];
  gnt_t gnt_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic prev_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_gnt(input int s, input logic [1:0] m);
    gnt_t g;
    g.src  = s;
    g.mode = m;
    gnt_q.push_back(g);
  endtask

  // Monitor: every FIFO write and every new grant is checked against the queues
  always @(negedge clk) begin
    if (fifo_wr) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_wr: got data 0x%0h expected no write", fifo_wdata);
      end else begin
        chk("wdata", fifo_wdata, exp_q[0].data);
        chk("wr_cycle", cyc, exp_q[0].cyc);
        chk("ovf_err", ovf_err, exp_q[0].ovf);
        exp_q.delete(0);
      end
    end else if (ovf_err) begin
      checks++;
      failures++;
      $display("FAIL stray_ovf: got ovf_err=1 expected 0 without write");
    end
    if (busy && !prev_busy) begin
      if (gnt_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_grant: got src %0d expected no grant", src_id);
      end else begin
        chk("grant_src", src_id, gnt_q[0].src);
        chk("grant_mode", mode_out, gnt_q[0].mode);
        gnt_q.delete(0);
      end
    end
    prev_busy <= busy;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    slv_mode = '0; slv_req = '0; slv_valid = '0; slv_data = '0; slv_last = '0;
    fifo_full = 1'b0; proc_cmplt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {slv_ready, fifo_wr, fifo_wdata, mode_out, src_id, busy, ovf_err}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Present n beats from source s; optional 3-cycle full stall before beat full_at
  task automatic send_frame(input int s, input int n, input logic [31:0] base,
                            input bit give_last, input int full_at, input bit ovf_last);
    int to;
    exp_t e;
    for (int b = 0; b < n; b++) begin
      slv_valid = '0;
      slv_valid[s] = 1'b1;
      slv_data[s*DW +: DW] = base + b;
      slv_last = '0;
      slv_last[s] = give_last && (b == n - 1);
      if (b == full_at) begin
        fifo_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          chk("full_ready", slv_ready, 0);
          if (c > 0) chk("full_no_wr", fifo_wr, 0);
          @(posedge clk);
          #1;
        end
        fifo_full = 1'b0;
      end
      to = 0;
      forever begin
        @(negedge clk);
        if (slv_ready[s]) break;
        to++;
        if (to > 100) begin
          checks++;
          failures++;
          $display("FAIL ready_timeout: got no ready for src %0d beat %0d expected ready", s, b);
          slv_valid = '0;
          slv_last = '0;
          return;
        end
      end
      e.data = base + b;
      e.ovf  = ovf_last && (b == n - 1);
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
    end
    slv_valid = '0;
    slv_last = '0;
  endtask

  // Frame is done: engine stays held in WAIT until the proc_cmplt pulse
  task automatic finish_frame();
    repeat (3) begin
      @(negedge clk);
      chk("wait_busy", busy, 1);
      chk("wait_ready", slv_ready, 0);
    end
    @(posedge clk);
    #1;
    proc_cmplt = 1'b1;
    @(posedge clk);
    #1;
    proc_cmplt = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: single 4-beat frame from source 0
    do_reset();
    push_gnt(0, 2'b01);
    slv_mode = 4'b0001; slv_req = 2'b01;
    send_frame(0, 4, 32'd1, 1'b1, -1, 1'b0);
    slv_req = '0;
    finish_frame();

    // 2: both sources continuously requesting alternate frames
    do_reset();
    push_gnt(0, 2'b01); push_gnt(1, 2'b01); push_gnt(0, 2'b01); push_gnt(1, 2'b01);
    slv_mode = 4'b0101; slv_req = 2'b11;
    send_frame(0, 2, 32'h100, 1'b1, -1, 1'b0); finish_frame();
    send_frame(1, 2, 32'h200, 1'b1, -1, 1'b0); finish_frame();
    send_frame(0, 2, 32'h300, 1'b1, -1, 1'b0); finish_frame();
    send_frame(1, 2, 32'h400, 1'b1, -1, 1'b0);
    slv_req = '0;
    finish_frame();

    // 3: FIFO full stall mid-frame (pointer is back at 0)
    push_gnt(0, 2'b01);
    slv_mode = 4'b0101; slv_req = 2'b01;
    send_frame(0, 4, 32'h30, 1'b1, 2, 1'b0);
    slv_req = '0;
    finish_frame();

    // 4: inactive-mode request is ignored until the mode becomes nonzero
    slv_mode = 4'b0001; slv_req = 2'b10;
    repeat (5) begin
      @(negedge clk);
      chk("inactive_busy", busy, 0);
      chk("inactive_ready", slv_ready, 0);
    end
    @(posedge clk);
    #1;
    push_gnt(1, 2'b10);
    slv_mode = 4'b1001;
    send_frame(1, 2, 32'h40, 1'b1, -1, 1'b0);
    slv_req = '0;
    finish_frame();

    // 5: source 0 never sends last; force-terminated after 8 beats, then source 1
    push_gnt(0, 2'b01);
    slv_mode = 4'b0101; slv_req = 2'b01;
    send_frame(0, MAXB, 32'h50, 1'b0, -1, 1'b1);
    push_gnt(1, 2'b01);
    slv_req = 2'b10;
    finish_frame();
    send_frame(1, 1, 32'h60, 1'b1, -1, 1'b0);
    slv_req = '0;
    finish_frame();

    // 6: full frame moves pointer to 1, then reset mid-frame restores pointer 0
    push_gnt(0, 2'b11); push_gnt(0, 2'b11);
    slv_mode = 4'b0111; slv_req = 2'b01;
    send_frame(0, 1, 32'h70, 1'b1, -1, 1'b0);
    finish_frame();
    send_frame(0, 1, 32'h80, 1'b0, -1, 1'b0);
    slv_valid[0] = 1'b1; slv_data[DW-1:0] = 32'h81; fifo_full = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {slv_ready, fifo_wr, fifo_wdata, mode_out, src_id, busy, ovf_err}, 0);
    slv_valid = '0; slv_req = '0; fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", busy, 0);
    @(posedge clk);
    #1;
    push_gnt(0, 2'b01);
    slv_mode = 4'b0101; slv_req = 2'b11;
    send_frame(0, 1, 32'h90, 1'b1, -1, 1'b0);
    slv_req = '0;
    finish_frame();

    repeat (5) @(posedge clk);
    #1;
    chk("exp_q_drained", exp_q.size(), 0);
    chk("gnt_q_drained", gnt_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
